if_id_queue: RTL and testbench
==============================

# if_id_queue

Instruction buffer between the fetch stage (program counter plus instruction memory) and the decode stage of the five-stage pipeline. It replaces a plain IF/ID register with a small circular FIFO of {pc, instruction} pairs. Fetch can run ahead while decode is stalled. A taken branch flushes every buffered instruction in one cycle.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2
- PTR_W, 2, pointer width, equal to log2(DEPTH)

Ports:
- clk  input  1  pipeline clock; all state changes on its rising edge
- rst  input  1  reset; asynchronous, active-high; clears all state immediately
- if_valid_i  input  1  a fetched pair is presented this cycle; fetch drives it low while its chip enable is off
- if_pc_i  input  32  address of the fetched instruction
- if_inst_i  input  32  fetched instruction word
- if_ready_o  output  1  queue can accept a push this cycle; fetch holds its PC when this is low
- flush_i  input  1  taken branch from execute; discard all entries
- id_ready_i  input  1  decode consumes the head entry this cycle (inverse of decode stall)
- id_valid_o  output  1  head entry present
- id_pc_o  output  32  head entry address; 32'h0 when empty
- id_inst_o  output  32  head entry instruction; 32'h0 (NOP) when empty
- count_o  output  PTR_W+1  number of occupied entries, 0..DEPTH

## Operation
Storage:
- Arrays pc_mem[DEPTH] and inst_mem[DEPTH].
- Write pointer wr_ptr and read pointer rd_ptr, each PTR_W bits.
- Occupancy counter cnt, PTR_W+1 bits.

Derived signals:
- empty = (cnt == 0)
- full = (cnt == DEPTH)
- if_ready_o = !full, combinational from registered cnt. A push is never accepted into a full queue, even if a pop occurs in the same cycle.
- push = if_valid_i & if_ready_o & !flush_i
- pop = id_ready_i & !empty & !flush_i

Per-cycle update, in priority order:
1. flush_i=1:
   - wr_ptr, rd_ptr and cnt all go to 0.
   - Any pair presented the same cycle is dropped. The memory arrays are not cleared.
2. push only:
   - Write the pair at wr_ptr.
   - wr_ptr advances by 1, wrapping modulo DEPTH.
   - cnt increments by 1.
3. pop only:
   - rd_ptr advances by 1, wrapping modulo DEPTH.
   - cnt decrements by 1.
4. push and pop together (only possible when 0 < cnt < DEPTH):
   - Write the pair at wr_ptr.
   - Both pointers advance.
   - cnt is unchanged.

Outputs:
- id_valid_o = !empty.
- id_pc_o and id_inst_o show pc_mem[rd_ptr] and inst_mem[rd_ptr] when not empty, and 32'h0 when empty.
- Decode always receives a NOP when the queue is empty.

Other rules:
- id_ready_i asserted while empty has no effect.
- if_valid_i while full has no effect. The fetch stage must hold that pair and retry.

## Timing
- Reset (asynchronous, active-high, takes effect without a clock edge):
  - wr_ptr=0, rd_ptr=0, cnt=0.
  - id_valid_o=0, id_pc_o=0, id_inst_o=0, count_o=0, if_ready_o=1.
- Latency: a pair pushed on edge N is visible on id_* after edge N. There is no same-cycle bypass from if_* to id_*.
- Throughput: one push and one pop per cycle in steady state.
- Flush on edge N: from after edge N, id_valid_o=0 and if_ready_o=1. The first post-branch fetch can be pushed on edge N+1.
- Reset deasserted mid-stream: the queue restarts empty. No pair from before reset ever appears on id_*.
- Wrap-around: pointer DEPTH-1 goes to 0 with no bubble.
- Full to not-full: a pop on edge N makes if_ready_o=1 after edge N. The push then lands on edge N+1.

## Test plan
- Reset then stream:
  - Stimulus: release rst; push pc 0x0,0x4,0x8 with insts 0x11,0x22,0x33 on three consecutive edges; id_ready_i=1 throughout.
  - Required: id_* shows (0x0,0x11),(0x4,0x22),(0x8,0x33) one cycle behind each push; count_o stays ≤1.
- Fill and back-pressure:
  - Stimulus: id_ready_i=0; push 5 pairs at DEPTH=4.
  - Required: count_o=4 and if_ready_o=0 after the 4th push; the 5th pair (pc 0x10) is not stored; id_pc_o stays 0x0.
- Drain with wrap:
  - Stimulus: from full, set id_ready_i=1 while pushing pc 0x10 and 0x14.
  - Required: output order 0x0,0x4,0x8,0xC,0x10,0x14 with no duplicate and no gap.
- Flush with concurrent push and pop:
  - Stimulus: with cnt=3, assert flush_i, if_valid_i=1 (pc 0x40) and id_ready_i=1 in the same cycle.
  - Required: after the edge, count_o=0, id_valid_o=0, id_inst_o=0; pc 0x40 never appears; a next push of pc 0x100 appears alone.
- Asynchronous reset mid-operation:
  - Stimulus: with cnt=2, pulse rst between clock edges.
  - Required: id_valid_o=0, count_o=0 and if_ready_o=1 before the next edge.
- Empty pop and idle:
  - Stimulus: id_ready_i=1 with no pushes for 5 cycles.
  - Required: count_o=0, id_pc_o=0, id_inst_o=0; pointers unchanged; a later push of (0x20,0xAA) appears correctly.

Source files
------------

// File: rtl/if_id_queue.sv
// ----------------------------------------------------------------------------
// if_id_queue : circular {pc, inst} buffer between fetch and decode, 1-cycle flush
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module if_id_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid_i,
  input  logic [31:0]      if_pc_i,
  input  logic [31:0]      if_inst_i,
  output logic             if_ready_o,
  input  logic             flush_i,
  input  logic             id_ready_i,
  output logic             id_valid_o,
  output logic [31:0]      id_pc_o,
  output logic [31:0]      id_inst_o,
  output logic [PTR_W:0]   count_o
);

  localparam logic [PTR_W:0]   C_DEPTH   = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   C_CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);

  logic [31:0]      pc_mem_q   [DEPTH];
  logic [31:0]      pc_mem_d   [DEPTH];
  logic [31:0]      inst_mem_q [DEPTH];
  logic [31:0]      inst_mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;

  // Full is judged on registered occupancy only, so a same-cycle pop never frees a slot.
  assign w_empty = (cnt_q == '0);
  assign w_full  = (cnt_q == C_DEPTH);
  assign w_push  = if_valid_i & ~w_full & ~flush_i;
  assign w_pop   = id_ready_i & ~w_empty & ~flush_i;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (w_push) begin
        pc_mem_d[wr_ptr_q]   = if_pc_i;
        inst_mem_d[wr_ptr_q] = if_inst_i;
        wr_ptr_d             = wr_ptr_q + C_PTR_ONE;
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + C_PTR_ONE;
      end
      if (w_push && !w_pop) begin
        cnt_d = cnt_q + C_CNT_ONE;
      end else if (w_pop && !w_push) begin
        cnt_d = cnt_q - C_CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload storage is never reset; occupancy gating hides stale contents.
  always_ff @(posedge clk) begin
    pc_mem_q   <= pc_mem_d;
    inst_mem_q <= inst_mem_d;
  end

  assign if_ready_o = ~w_full;
  assign id_valid_o = ~w_empty;
  assign id_pc_o    = w_empty ? 32'h0 : pc_mem_q[rd_ptr_q];
  assign id_inst_o  = w_empty ? 32'h0 : inst_mem_q[rd_ptr_q];
  assign count_o    = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_if_id_queue.sv
// ----------------------------------------------------------------------------
// tb_if_id_queue : table-driven self-checking bench for if_id_queue
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_if_id_queue;

  logic        clk;
  logic        rst;
  logic        if_valid_i;
  logic [31:0] if_pc_i;
  logic [31:0] if_inst_i;
  logic        if_ready_o;
  logic        flush_i;
  logic        id_ready_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic [2:0]  count_o;

  int checks;
  int failures;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        flush;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [2:0]  e_cnt;
    logic        e_ready;
  } vec_t;

  vec_t vecs[$];

  if_id_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_valid_i (if_valid_i),
    .if_pc_i    (if_pc_i),
    .if_inst_i  (if_inst_i),
    .if_ready_o (if_ready_o),
    .flush_i    (flush_i),
    .id_ready_i (id_ready_i),
    .id_valid_o (id_valid_o),
    .id_pc_o    (id_pc_o),
    .id_inst_o  (id_inst_o),
    .count_o    (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [31:0] epc,
                         input logic [31:0] einst, input logic [2:0] ecnt, input logic erdy);
    chk({tag, " id_valid"}, {31'b0, id_valid_o}, {31'b0, ev});
    chk({tag, " id_pc"}, id_pc_o, epc);
    chk({tag, " id_inst"}, id_inst_o, einst);
    chk({tag, " count"}, {29'b0, count_o}, {29'b0, ecnt});
    chk({tag, " if_ready"}, {31'b0, if_ready_o}, {31'b0, erdy});
  endtask

  task automatic add(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                     input logic fl, input logic rdy, input logic ev, input logic [31:0] epc,
                     input logic [31:0] einst, input logic [2:0] ecnt, input logic erdy);
    vec_t t;
    t = '{valid: v, pc: pc, inst: inst, flush: fl, rdy: rdy,
          e_valid: ev, e_pc: epc, e_inst: einst, e_cnt: ecnt, e_ready: erdy};
    vecs.push_back(t);
  endtask

  // Drive inputs, take one rising edge, sample 1 time unit later.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                      input logic fl, input logic rdy);
    if_valid_i = v;
    if_pc_i    = pc;
    if_inst_i  = inst;
    flush_i    = fl;
    id_ready_i = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    if_valid_i = 1'b0;
    if_pc_i = '0;
    if_inst_i = '0;
    flush_i = 1'b0;
    id_ready_i = 1'b0;

    //   v  pc          inst        fl rdy  ev epc         einst       cnt rdy
    // reset then stream
    add(1, 32'h0,   32'h11, 0, 1,  1, 32'h0,   32'h11, 3'd1, 1);
    add(1, 32'h4,   32'h22, 0, 1,  1, 32'h4,   32'h22, 3'd1, 1);
    add(1, 32'h8,   32'h33, 0, 1,  1, 32'h8,   32'h33, 3'd1, 1);
    add(0, 32'h0,   32'h0,  0, 1,  0, 32'h0,   32'h0,  3'd0, 1);
    // fill and back-pressure
    add(1, 32'h0,   32'hA0, 0, 0,  1, 32'h0,   32'hA0, 3'd1, 1);
    add(1, 32'h4,   32'hA4, 0, 0,  1, 32'h0,   32'hA0, 3'd2, 1);
    add(1, 32'h8,   32'hA8, 0, 0,  1, 32'h0,   32'hA0, 3'd3, 1);
    add(1, 32'hC,   32'hAC, 0, 0,  1, 32'h0,   32'hA0, 3'd4, 0);
    add(1, 32'h10,  32'hB0, 0, 0,  1, 32'h0,   32'hA0, 3'd4, 0);
    // drain with wrap: push refused while full even with a pop
    add(1, 32'h10,  32'hB0, 0, 1,  1, 32'h4,   32'hA4, 3'd3, 1);
    add(1, 32'h10,  32'hB0, 0, 1,  1, 32'h8,   32'hA8, 3'd3, 1);
    add(1, 32'h14,  32'hB4, 0, 1,  1, 32'hC,   32'hAC, 3'd3, 1);
    add(0, 32'h0,   32'h0,  0, 1,  1, 32'h10,  32'hB0, 3'd2, 1);
    add(0, 32'h0,   32'h0,  0, 1,  1, 32'h14,  32'hB4, 3'd1, 1);
    add(0, 32'h0,   32'h0,  0, 1,  0, 32'h0,   32'h0,  3'd0, 1);
    // flush with concurrent push and pop
    add(1, 32'h20,  32'hC0, 0, 0,  1, 32'h20,  32'hC0, 3'd1, 1);
    add(1, 32'h24,  32'hC4, 0, 0,  1, 32'h20,  32'hC0, 3'd2, 1);
    add(1, 32'h28,  32'hC8, 0, 0,  1, 32'h20,  32'hC0, 3'd3, 1);
    add(1, 32'h40,  32'hE0, 1, 1,  0, 32'h0,   32'h0,  3'd0, 1);
    add(1, 32'h100, 32'hF0, 0, 0,  1, 32'h100, 32'hF0, 3'd1, 1);
    add(0, 32'h0,   32'h0,  0, 1,  0, 32'h0,   32'h0,  3'd0, 1);
    // empty pop and idle
    for (int i = 0; i < 5; i++)
      add(0, 32'h0, 32'h0,  0, 1,  0, 32'h0,   32'h0,  3'd0, 1);
    add(1, 32'h20,  32'hAA, 0, 0,  1, 32'h20,  32'hAA, 3'd1, 1);
    add(1, 32'h30,  32'hBB, 0, 0,  1, 32'h20,  32'hAA, 3'd2, 1);

    #12;
    chk_all("reset", 1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      step(vecs[i].valid, vecs[i].pc, vecs[i].inst, vecs[i].flush, vecs[i].rdy);
      chk_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_inst,
              vecs[i].e_cnt, vecs[i].e_ready);
    end

    // asynchronous reset mid-cycle with two entries held
    if_valid_i = 1'b0;
    id_ready_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_all("post_rst_idle", 1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
    step(1'b1, 32'h44, 32'hCC, 1'b0, 1'b1);
    chk_all("post_rst_push", 1'b1, 32'h44, 32'hCC, 3'd1, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk_all("post_rst_drain", 1'b0, 32'h0, 32'h0, 3'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
